// File: rtl/cordic_rot_iter_pkg.sv
// Fixed-point constants shared by the rotation and vectoring CORDIC.
// Format: 1 sign, 1 integer, 14 fraction bits.
package cordic_rot_iter_pkg;

  localparam int SYM_W = 1;
  localparam int INT_W = 1;
  localparam int DEC_W = 14;
  localparam int FX_W  = SYM_W + INT_W + DEC_W;

  localparam logic [15:0] INV_K   = 16'h26DD;
  localparam logic [15:0] PI_HALF = 16'h6487;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [15:0] atan_val(
    input logic [3:0] i
  );
    case (i)
      4'd0:    atan_val = 16'h3242;
      4'd1:    atan_val = 16'h1DAB;
      4'd2:    atan_val = 16'h0FAC;
      4'd3:    atan_val = 16'h07F6;
      4'd4:    atan_val = 16'h03FE;
      4'd5:    atan_val = 16'h01FF;
      4'd6:    atan_val = 16'h00FF;
      4'd7:    atan_val = 16'h007F;
      4'd8:    atan_val = 16'h003F;
      4'd9:    atan_val = 16'h0020;
      default: atan_val = 16'h4000 >> i;
    endcase
  endfunction

endpackage

// File: rtl/cordic_rot_iter_if.sv
// Angle-in / cos-sin-out handshake bundle.
// master drives the request, slave is the CORDIC.
interface cordic_rot_iter_if #(
  parameter int W = 16
);

  logic                data_ready;
  logic signed [W-1:0] angle;
  logic                in_ready;
  logic                data_valid;
  logic signed [W-1:0] cos;
  logic signed [W-1:0] sin;

  modport master (
    output data_ready,
    output angle,
    input  in_ready,
    input  data_valid,
    input  cos,
    input  sin
  );

  modport slave (
    input  data_ready,
    input  angle,
    output in_ready,
    output data_valid,
    output cos,
    output sin
  );

endinterface

// File: rtl/cordic_rot_step.sv
// One combinational rotation-mode CORDIC micro-rotation.
// Direction follows the sign of the residual angle z.
module cordic_rot_step #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic signed [W-1:0] z,
  input  logic        [3:0]   sh,
  input  logic signed [W-1:0] atan,
  output logic signed [W-1:0] x_nxt,
  output logic signed [W-1:0] y_nxt,
  output logic signed [W-1:0] z_nxt
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  assign x_sh = x >>> sh;
  assign y_sh = y >>> sh;

  always_comb begin
    x_nxt = x - y_sh;
    y_nxt = y + x_sh;
    z_nxt = z - atan;
    if (z[W-1]) begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan;
    end
  end

endmodule

// File: rtl/cordic_rot_iter.sv
// Iterative rotation-mode CORDIC: one shared micro-rotation per cycle.
// Produces gain-compensated cos/sin of a saturated input angle.
module cordic_rot_iter
  import cordic_rot_iter_pkg::*;
#(
  parameter int SYM_WIDTH = SYM_W,
  parameter int INT_WIDTH = INT_W,
  parameter int DEC_WIDTH = DEC_W,
  parameter int ITER      = 10
) (
  input logic              clk,
  input logic              rstn,
  cordic_rot_iter_if.slave bus
);

  localparam int W = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;

  localparam logic signed [W-1:0] A_MAX =
    $signed(W'(PI_HALF));
  localparam logic signed [W-1:0] A_MIN = -A_MAX;
  localparam logic signed [W-1:0] X_INIT =
    $signed(W'(INV_K));
  localparam logic [3:0] LAST = 4'(ITER - 1);

  state_t              state;
  state_t              state_nxt;
  logic        [3:0]   cnt;
  logic signed [W-1:0] x;
  logic signed [W-1:0] y;
  logic signed [W-1:0] z;
  logic signed [W-1:0] x_nxt;
  logic signed [W-1:0] y_nxt;
  logic signed [W-1:0] z_nxt;
  logic signed [W-1:0] ang_sat;
  logic signed [W-1:0] atan;
  logic signed [W-1:0] cos_q;
  logic signed [W-1:0] sin_q;
  logic                valid_q;
  logic                accept;

  assign bus.in_ready   = (state == IDLE);
  assign bus.data_valid = valid_q;
  assign bus.cos        = cos_q;
  assign bus.sin        = sin_q;

  assign accept = bus.data_ready && (state == IDLE);
  assign atan   = $signed(W'(atan_val(cnt)));

  // Beyond +/-pi/2 the CORDIC does not converge.
  always_comb begin
    ang_sat = bus.angle;
    if (bus.angle > A_MAX) ang_sat = A_MAX;
    if (bus.angle < A_MIN) ang_sat = A_MIN;
  end

  cordic_rot_step #(.W(W)) u_step (
    .x     (x),
    .y     (y),
    .z     (z),
    .sh    (cnt),
    .atan  (atan),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .z_nxt (z_nxt)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (cnt == LAST) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            x   <= X_INIT;
            y   <= '0;
            z   <= ang_sat;
            cnt <= '0;
          end
        end
        RUN: begin
          x   <= x_nxt;
          y   <= y_nxt;
          z   <= z_nxt;
          cnt <= cnt + 4'd1;
        end
        DONE: begin
          cos_q   <= x;
          sin_q   <= y;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rot_iter.sv
// Directed bench for cordic_rot_iter: reset, angles,
// saturation, back-to-back requests and mid-run reset.
module tb_cordic_rot_iter;

  localparam int TOL = 40;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  cordic_rot_iter_if #(.W(16)) bus ();

  cordic_rot_iter dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int adiff(
    input logic signed [15:0] a,
    input int t
  );
    int d;
    d = int'(a) - t;
    return (d < 0) ? -d : d;
  endfunction

  task automatic do_op(
    input  logic [15:0]        a,
    output logic signed [15:0] c,
    output logic signed [15:0] s,
    output int                 lat
  );
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    bus.angle      = a;
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
    lat = 0;
    while (!bus.data_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (w >= 40) lat = -1;
    c = bus.cos;
    s = bus.sin;
  endtask

  task automatic test_reset();
    rstn           = 1'b0;
    bus.data_ready = 1'b0;
    bus.angle      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_in_ready got %b want 1", bus.in_ready);
    end
    n_cmp++;
    if (bus.data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_valid got %b want 0", bus.data_valid);
    end
    n_cmp++;
    if (bus.cos !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_cos got %h want 0000", bus.cos);
    end
    n_cmp++;
    if (bus.sin !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_sin got %h want 0000", bus.sin);
    end
  endtask

  task automatic test_zero();
    logic signed [15:0] c;
    logic signed [15:0] s;
    int lat;
    do_op(16'h0000, c, s, lat);
    n_cmp++;
    if (lat !== 11) begin
      n_err++;
      $display("FAIL zero_latency got %0d want 11", lat);
    end
    n_cmp++;
    if (adiff(c, 16384) > TOL) begin
      n_err++;
      $display("FAIL zero_cos got %h want 4000+-40", c);
    end
    n_cmp++;
    if (adiff(s, 0) > TOL) begin
      n_err++;
      $display("FAIL zero_sin got %h want 0000+-40", s);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_pulse got %b want 0", bus.data_valid);
    end
    n_cmp++;
    if (adiff(bus.cos, 16384) > TOL) begin
      n_err++;
      $display("FAIL zero_hold got %h want 4000+-40", bus.cos);
    end
  endtask

  task automatic test_pi4();
    logic signed [15:0] c;
    logic signed [15:0] s;
    int lat;
    do_op(16'h3243, c, s, lat);
    n_cmp++;
    if (adiff(c, 11585) > TOL || adiff(s, 11585) > TOL) begin
      n_err++;
      $display("FAIL pi4 got cos %h sin %h want 2d41/2d41", c, s);
    end
    do_op(16'hCDBD, c, s, lat);
    n_cmp++;
    if (lat !== 11) begin
      n_err++;
      $display("FAIL npi4_latency got %0d want 11", lat);
    end
    n_cmp++;
    if (adiff(c, 11585) > TOL || adiff(s, -11585) > TOL) begin
      n_err++;
      $display("FAIL npi4 got cos %h sin %h want 2d41/d2bf", c, s);
    end
  endtask

  task automatic test_saturate();
    logic signed [15:0] c;
    logic signed [15:0] s;
    int lat;
    do_op(16'h7FFF, c, s, lat);
    n_cmp++;
    if (adiff(c, 0) > TOL || adiff(s, 16384) > TOL) begin
      n_err++;
      $display("FAIL sat_pos got cos %h sin %h want 0000/4000", c, s);
    end
    do_op(16'h6487, c, s, lat);
    n_cmp++;
    if (adiff(c, 0) > TOL || adiff(s, 16384) > TOL) begin
      n_err++;
      $display("FAIL pi2 got cos %h sin %h want 0000/4000", c, s);
    end
    do_op(16'h8000, c, s, lat);
    n_cmp++;
    if (adiff(c, 0) > TOL || adiff(s, -16384) > TOL) begin
      n_err++;
      $display("FAIL sat_neg got cos %h sin %h want 0000/c000", c, s);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    logic exp_vld;
    @(negedge clk);
    bus.angle      = 16'h0000;
    bus.data_ready = 1'b1;
    for (int k = 0; k <= 48; k++) begin
      if (k > 0) @(negedge clk);
      exp_rdy = (k % 12 == 0);
      exp_vld = (k > 0) && (k % 12 == 0);
      n_cmp++;
      if (bus.in_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL b2b_rdy k=%0d got %b want %b",
                 k, bus.in_ready, exp_rdy);
      end
      n_cmp++;
      if (bus.data_valid !== exp_vld) begin
        n_err++;
        $display("FAIL b2b_vld k=%0d got %b want %b",
                 k, bus.data_valid, exp_vld);
      end
      if (exp_vld) begin
        n_cmp++;
        if (adiff(bus.cos, 16384) > TOL) begin
          n_err++;
          $display("FAIL b2b_cos k=%0d got %h want 4000", k, bus.cos);
        end
      end
    end
    bus.data_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic signed [15:0] c;
    logic signed [15:0] s;
    int lat;
    int pulses;
    @(negedge clk);
    bus.angle      = 16'h3243;
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_rdy got %b want 1", bus.in_ready);
    end
    n_cmp++;
    if (bus.cos !== 16'h0000 || bus.sin !== 16'h0000) begin
      n_err++;
      $display("FAIL abort_out got cos %h sin %h want 0000/0000",
               bus.cos, bus.sin);
    end
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.data_valid) pulses++;
      @(negedge clk);
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL abort_pulse got %0d want 0", pulses);
    end
    do_op(16'hCDBD, c, s, lat);
    n_cmp++;
    if (lat !== 11) begin
      n_err++;
      $display("FAIL post_latency got %0d want 11", lat);
    end
    n_cmp++;
    if (adiff(c, 11585) > TOL || adiff(s, -11585) > TOL) begin
      n_err++;
      $display("FAIL post got cos %h sin %h want 2d41/d2bf", c, s);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_zero();
    test_pi4();
    test_saturate();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_rot_iter.md
CORDIC_ROT_ITER -- requirements
Module: cordic_rot_iter

Interface
REQ-001 SHALL have parameter SYM_WIDTH, default 1, sign bits of the fixed-point format.
REQ-002 SHALL have parameter INT_WIDTH, default 1, integer bits.
REQ-003 SHALL have parameter DEC_WIDTH, default 14, fraction bits; W = SYM_WIDTH+INT_WIDTH+DEC_WIDTH (16 by default).
REQ-004 SHALL have parameter ITER, default 10, number of micro-rotations (1..16).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 data_ready  input  1  start request; angle sampled when data_ready && in_ready.
REQ-008 angle  input  W signed  rotation angle in radians, two's-complement fixed point.
REQ-009 in_ready  output  1  high only when the block can accept a new angle.
REQ-010 data_valid  output  1  one-cycle pulse marking new cos/sin results.
REQ-011 cos  output  W signed  cos(angle), gain-compensated.
REQ-012 sin  output  W signed  sin(angle), gain-compensated.

Function
REQ-013 SHALL implement rotation-mode CORDIC iteratively, one micro-rotation per cycle, sharing one datapath stage.
REQ-014 SHALL use states IDLE, RUN and DONE; IDLE->RUN on accept; RUN->DONE when the iteration counter reaches ITER-1; DONE->IDLE unconditionally.
REQ-015 On accept SHALL load x = 1/K = 0x26DD (0.60725), y = 0, z = saturated angle, counter = 0.
REQ-016 SHALL saturate the angle to +/-0x6487 (+/-pi/2) before loading; in-range angles pass unchanged.
REQ-017 In RUN step i: d = +1 if z >= 0 else -1; x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan(2^-i); shifts arithmetic.
REQ-018 atan table SHALL be 0x3242, 0x1DAB, 0x0FAC, 0x07F6, 0x03FE, 0x01FF, 0x00FF, 0x007F, 0x003F, 0x0020 for i = 0..9; entries beyond 9 are 2^(14-i).
REQ-019 x/y/z arithmetic SHALL be W bits with wrap-around; no intermediate widening is required for saturated inputs.
REQ-020 In DONE, cos <= x, sin <= y and data_valid = 1 for exactly that cycle.
REQ-021 Latency SHALL be ITER+1 cycles from the accept edge to the data_valid cycle (11 by default); throughput one result per ITER+2 cycles.
REQ-022 in_ready SHALL be 1 in IDLE and 0 in RUN and DONE; data_ready while in_ready = 0 is ignored and not queued.
REQ-023 cos/sin SHALL hold their last values until the next DONE.

Reset
REQ-024 With rstn = 0 at a clock edge: state IDLE, counter 0, x/y/z 0, cos 0, sin 0, data_valid 0, in_ready 1 on the following cycle.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no data_valid pulse for it.

Structure
REQ-026 Shared package SHALL hold the fixed-point width parameters, the atan table constants and the 1/K constant, shared with the vectoring-mode CORDIC.
REQ-027 One sub-module SHALL be used: cordic_rot_step, combinational single micro-rotation (inputs x, y, z, shift i, atan value; outputs x', y', z').

Verification
REQ-028 angle 0x0000 -> after 11 cycles, data_valid pulse, cos within 0x4000 +/-40 LSB, sin within 0x0000 +/-40 LSB.
REQ-029 angle 0x3243 (pi/4) -> cos and sin each within 0x2D41 +/-40 LSB; angle 0xCDBD (-pi/4) -> cos within 0x2D41 +/-40 LSB, sin within 0xD2BF +/-40 LSB.
REQ-030 angle 0x7FFF and angle 0x6487 -> identical results, cos within 0x0000 +/-40 LSB, sin within 0x4000 +/-40 LSB.
REQ-031 data_ready held high continuously -> accepts every 12 cycles, in_ready low during RUN/DONE, one data_valid per accept.
REQ-032 rstn low at cycle 5 of RUN -> no data_valid, cos/sin read 0, in_ready 1 afterwards; next request completes normally.
